regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-read/single-write register file.
- Adds:
  - configurable numbers of read and write ports;
  - registered (1-cycle) reads with write-to-read bypass;
  - defined write-port priority;
  - a per-register pending scoreboard.
- Sits between decode (reads, reservations) and writeback (writes) in the core pipeline.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers (need not be a power of two); AW = max(1, $clog2(DEPTH)).
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports; a higher index has higher priority.

Ports:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i is at [i*AW +: AW].
- rd_data  out  NUM_RD*WIDTH  packed registered read data.
- rd_valid  out  NUM_RD  rd_data for port i is valid this cycle.
- wr_en  in  NUM_WR  per-port write strobe.
- wr_addr  in  NUM_WR*AW  packed write addresses.
- wr_data  in  NUM_WR*WIDTH  packed write data.
- rsv_en  in  1  mark a register as pending (destination reserved).
- rsv_addr  in  AW  register to reserve.
- pend  out  DEPTH  pending bitmap; bit k set means a write to register k is outstanding.

Behaviour:
- Reset, sampled at posedge clk while rst=1:
  - all registers, rd_data, rd_valid and pend go to 0;
  - rst overrides every other input in the same cycle;
  - reset mid-operation discards in-flight reads: rd_valid=0 in the following cycle.
- Write:
  - at posedge, for each port j with wr_en[j]=1 and wr_addr[j] < DEPTH, reg[wr_addr[j]] <= wr_data[j].
  - If several enabled ports target the same address, the highest index j wins. The other ports' writes are dropped silently.
- Read:
  - latency is exactly 1 cycle: inputs sampled at edge N produce rd_data/rd_valid after edge N.
  - rd_en[i]=1 registers rd_valid[i]=1 and rd_data[i]. rd_en[i]=0 registers rd_valid[i]=0 and rd_data[i]=0.
- Bypass: if rd_addr[i] matches an enabled write address in the same cycle, rd_data[i] returns the winning wr_data, i.e. the new value, not the stale one.
- Out-of-range address (≥ DEPTH):
  - write is ignored;
  - read returns rd_data=0 with rd_valid=1.
- Scoreboard:
  - rsv_en=1 sets pend[rsv_addr];
  - any enabled in-range write clears pend[wr_addr];
  - a reservation and a write to the same address in the same cycle leave pend set (set wins).
  - Reserving an already-pending register keeps it set.
  - An out-of-range rsv_addr is ignored.
  - pend is a direct register output and is not bypassed.
- Read ports are independent. Any number of ports may read the same address in one cycle.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired to 0;
  - writes to address 0 are dropped and do not win priority over other ports;
  - reads and bypass of address 0 return 0;
  - pend[0] is constantly 0 and rsv to 0 is ignored.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package regfile_pkg holds:
  - function regfile_aw(depth) returning max(1, $clog2(depth));
  - default WIDTH/DEPTH localparams;
  - typedef regfile_port_t struct {en, addr, data} for documentation and bench use.
- Sub-module regfile_scoreboard contains pend set/clear logic parametrised by DEPTH, NUM_WR and AW.
- Storage, priority resolution and the read/bypass mux remain in regfile_mp.

Test Plan:
1. Reset, then write reg5=0xDEADBEEF via port 0; next cycle rd_en[0]=1 with addr 5 -> one cycle later rd_data[0]=0xDEADBEEF and rd_valid[0]=1; rd_en=0 on the following cycle -> rd_valid=0 and rd_data=0.
2. Same cycle: wr port0 reg3=0x11, wr port1 reg3=0x22, rd port1 addr 3 -> rd_data[1]=0x22 (bypass plus priority); a later read of reg3 returns 0x22.
3. rsv_en with addr 7 -> pend[7]=1; next cycle write reg7 -> pend[7]=0; same-cycle rsv and write to reg9 -> pend[9]=1.
4. Write regs 1..4, assert rst for one cycle concurrently with reads and writes -> rd_valid=0, pend=0, and all registers read 0 afterwards.
5. DEPTH=20: write to addr 25 has no effect on any register; read of addr 25 -> rd_data=0, rd_valid=1.
6. With REGFILE_ZERO_REG_EN defined: write reg0=0xFF while another port writes reg0=0x0 -> reg0 reads 0; rsv of 0 leaves pend[0]=0. Without the macro, reg0 holds the written value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// address-width helper and a port bundle type for documentation/bench use.
package regfile_pkg;

  localparam int REGFILE_WIDTH_DEF = 32;
  localparam int REGFILE_DEPTH_DEF = 32;

  // Address width for a given depth, never narrower than one bit.
  function automatic int regfile_aw(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int REGFILE_AW_DEF = regfile_aw(REGFILE_DEPTH_DEF);

  typedef struct packed {
    logic                         en;
    logic [REGFILE_AW_DEF-1:0]    addr;
    logic [REGFILE_WIDTH_DEF-1:0] data;
  } regfile_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a reservation from
// decode and cleared by a committed write from writeback. Set wins a tie.
// Honours REGFILE_ZERO_REG_EN: register 0 can never become pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = REGFILE_DEPTH_DEF,
  parameter int NUM_WR = 2,
  parameter int AW     = regfile_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wr_we_i,    // already filtered: in range and allowed
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_addr_i,
  output logic [DEPTH-1:0]     pend_o
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             rsv_ok;

  // Reservation is accepted only for a real, writable register.
  always_comb begin
    rsv_ok = rsv_en_i && (int'(rsv_addr_i) < DEPTH);
`ifdef REGFILE_ZERO_REG_EN
    if (rsv_addr_i == '0) rsv_ok = 1'b0;
`endif
  end

  // Apply write clears first, then the reservation so that set wins.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_we_i[j]) pend_d[wr_addr_i[j*AW +: AW]] = 1'b0;
    end
    if (rsv_ok) pend_d[rsv_addr_i] = 1'b1;
  end

  // Pending bitmap register.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, write-to-read bypass,
// index-ordered write priority (highest port wins) and a pending scoreboard.
// Optional: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REGFILE_WIDTH_DEF,
  parameter int DEPTH  = REGFILE_DEPTH_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_RD-1:0]                    rd_en,
  input  logic [NUM_RD*regfile_aw(DEPTH)-1:0]  rd_addr,
  output logic [NUM_RD*WIDTH-1:0]              rd_data,
  output logic [NUM_RD-1:0]                    rd_valid,
  input  logic [NUM_WR-1:0]                    wr_en,
  input  logic [NUM_WR*regfile_aw(DEPTH)-1:0]  wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]              wr_data,
  input  logic                                 rsv_en,
  input  logic [regfile_aw(DEPTH)-1:0]         rsv_addr,
  output logic [DEPTH-1:0]                     pend
);

  localparam int AW = regfile_aw(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_d;
  logic [NUM_WR-1:0]           wr_we;
  logic [NUM_RD*WIDTH-1:0]     rd_data_q;
  logic [NUM_RD*WIDTH-1:0]     rd_data_d;
  logic [NUM_RD-1:0]           rd_valid_q;

  // True when a write to this address may land in storage.
  function automatic logic wr_addr_ok(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return (int'(a) < DEPTH) && (a != '0);
`else
    return int'(a) < DEPTH;
`endif
  endfunction

  // Qualify each write port; dropped writes never take part in priority.
  always_comb begin
    wr_we = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_we[j] = wr_en[j] && wr_addr_ok(wr_addr[j*AW +: AW]);
    end
  end

  // Next storage state: ports applied in ascending order so the highest wins.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_we[j]) mem_d[wr_addr[j*AW +: AW]] = wr_data[j*WIDTH +: WIDTH];
    end
  end

  // Read mux taps post-write state, which gives bypass with correct priority.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_en[i] && (int'(rd_addr[i*AW +: AW]) < DEPTH)) begin
        rd_data_d[i*WIDTH +: WIDTH] = mem_d[rd_addr[i*AW +: AW]];
      end
    end
  end

  // Storage and registered read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_we_i    (wr_we),
    .wr_addr_i  (wr_addr),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .pend_o     (pend)
  );

endmodule
